// File: rtl/im_boot_ctrl.sv
// Boot-time loader: streams a host program image into instruction memory while
// holding the core in reset, then releases it. Tracks word count, XOR checksum
// and a truncation flag for host-side verification.
module im_boot_ctrl #(
  parameter int NMEM = 128,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_start,
  input  logic          host_valid,
  input  logic [31:0]   host_data,
  input  logic          host_last,
  output logic          host_ready,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [31:0]   im_wdata,
  output logic          cpu_rst,
  output logic [AW:0]   load_count,
  output logic [31:0]   load_sum,
  output logic          load_err,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Count value at which the next accept fills the memory.
  localparam logic [AW:0] LAST_CNT = (AW+1)'(NMEM - 1);

  state_t          state_q, state_d;
  logic            im_we_q, im_we_d;
  logic [AW-1:0]   im_waddr_q, im_waddr_d;
  logic [31:0]     im_wdata_q, im_wdata_d;
  logic [AW:0]     load_count_q, load_count_d;
  logic [31:0]     load_sum_q, load_sum_d;
  logic            load_err_q, load_err_d;
  logic            accept;
  logic            mem_full;

  // host_start takes priority, so no word is taken in a restart cycle.
  assign host_ready = (state_q == ST_LOAD) && !host_start;
  assign accept     = host_valid && host_ready;
  assign mem_full   = (load_count_q == LAST_CNT);

  always_comb begin
    state_d      = state_q;
    im_we_d      = 1'b0;
    im_waddr_d   = im_waddr_q;
    im_wdata_d   = im_wdata_q;
    load_count_d = load_count_q;
    load_sum_d   = load_sum_q;
    load_err_d   = load_err_q;
    if (host_start) begin
      state_d      = ST_LOAD;
      load_count_d = '0;
      load_sum_d   = '0;
      load_err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_LOAD: begin
          if (accept) begin
            im_we_d      = 1'b1;
            im_waddr_d   = load_count_q[AW-1:0];
            im_wdata_d   = host_data;
            load_count_d = load_count_q + 1'b1;
            load_sum_d   = load_sum_q ^ host_data;
            if (host_last || mem_full) begin
              state_d = ST_FLUSH;
            end
            if (!host_last && mem_full) begin
              load_err_d = 1'b1;
            end
          end
        end
        ST_FLUSH: state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      im_we_q      <= 1'b0;
      im_waddr_q   <= '0;
      im_wdata_q   <= '0;
      load_count_q <= '0;
      load_sum_q   <= '0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      im_we_q      <= im_we_d;
      im_waddr_q   <= im_waddr_d;
      im_wdata_q   <= im_wdata_d;
      load_count_q <= load_count_d;
      load_sum_q   <= load_sum_d;
      load_err_q   <= load_err_d;
    end
  end

  assign im_we      = im_we_q;
  assign im_waddr   = im_waddr_q;
  assign im_wdata   = im_wdata_q;
  assign cpu_rst    = (state_q != ST_RUN);
  assign load_count = load_count_q;
  assign load_sum   = load_sum_q;
  assign load_err   = load_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_im_boot_ctrl.sv
// Bench for im_boot_ctrl: a behavioural image-loader model checked every cycle,
// directed scenarios with literal expectations, and randomized loads.
module tb_im_boot_ctrl;
  localparam int NMEM = 128;
  localparam int AW   = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_start = 1'b0;
  logic          host_valid = 1'b0;
  logic [31:0]   host_data = '0;
  logic          host_last = 1'b0;
  logic          host_ready;
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic [AW:0]   load_count;
  logic [31:0]   load_sum;
  logic          load_err;
  logic [1:0]    state;

  im_boot_ctrl #(.NMEM(NMEM), .AW(AW)) dut (
    .clk(clk), .reset(reset), .host_start(host_start), .host_valid(host_valid),
    .host_data(host_data), .host_last(host_last), .host_ready(host_ready),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata), .cpu_rst(cpu_rst),
    .load_count(load_count), .load_sum(load_sum), .load_err(load_err), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 loading, 2 image complete, 3 core running.
  logic [1:0]    m_ph = 2'd0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wdata = '0;
  logic [AW:0]   m_cnt = '0;
  logic [31:0]   m_sum = '0;
  logic          m_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= 2'd0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_cnt <= '0; m_sum <= '0; m_err <= 1'b0;
    end else if (host_start) begin
      m_ph <= 2'd1; m_we <= 1'b0; m_cnt <= '0; m_sum <= '0; m_err <= 1'b0;
    end else if (m_ph == 2'd1 && host_valid) begin
      m_we    <= 1'b1;
      m_addr  <= m_cnt[AW-1:0];
      m_wdata <= host_data;
      m_cnt   <= m_cnt + 1'b1;
      m_sum   <= m_sum ^ host_data;
      if (host_last || (32'(m_cnt) + 1 == NMEM)) begin
        m_ph  <= 2'd2;
        m_err <= !host_last;
      end
    end else begin
      m_we <= 1'b0;
      if (m_ph == 2'd2) m_ph <= 2'd3;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_ph));
      chk("host_ready", 32'(host_ready), 32'(m_ph == 2'd1 && !host_start));
      chk("cpu_rst", 32'(cpu_rst), 32'(m_ph != 2'd3));
      chk("im_we", 32'(im_we), 32'(m_we));
      if (m_we) begin
        chk("im_waddr", 32'(im_waddr), 32'(m_addr));
        chk("im_wdata", im_wdata, m_wdata);
      end
      chk("load_count", 32'(load_count), 32'(m_cnt));
      chk("load_sum", load_sum, m_sum);
      chk("load_err", 32'(load_err), 32'(m_err));
    end
  end

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wa_q.push_back(im_waddr);
      wd_q.push_back(im_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    host_start = 1'b1; host_valid = 1'b0; host_last = 1'b0;
    tick();
    host_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    host_valid = 1'b1; host_data = d; host_last = last;
    tick();
    host_valid = 1'b0; host_last = 1'b0;
  endtask

  task automatic wait_run();
    int k = 0;
    while (state !== 2'd3 && k < 10) begin
      tick();
      k++;
    end
    chk("wait_run", 32'(state), 32'd3);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_ready"}, 32'(host_ready), 32'd0);
    chk({tag, "_we"}, 32'(im_we), 32'd0);
    chk({tag, "_waddr"}, 32'(im_waddr), 32'd0);
    chk({tag, "_wdata"}, im_wdata, 32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_count"}, 32'(load_count), 32'd0);
    chk({tag, "_sum"}, load_sum, 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [4];
    bit          vpat [7];
    int          w;
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    vpat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // 4-word back-to-back load
    do_start();
    clear_log();
    for (int i = 0; i < 4; i++) send(words[i], i == 3);
    chk("b2b_flush_state", 32'(state), 32'd2);
    chk("b2b_flush_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("b2b_flush_we", 32'(im_we), 32'd1);
    chk("b2b_flush_waddr", 32'(im_waddr), 32'd3);
    chk("b2b_flush_wdata", im_wdata, 32'h44444444);
    tick();
    chk("b2b_run_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("b2b_nwrites", 32'(wa_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      chk("b2b_waddr", 32'(wa_q[i]), 32'(i));
      chk("b2b_wdata", wd_q[i], words[i]);
    end
    chk("b2b_count", 32'(load_count), 32'd4);
    chk("b2b_sum", load_sum, 32'h44444444);
    chk("b2b_err", 32'(load_err), 32'd0);

    // throttled host
    do_start();
    clear_log();
    w = 0;
    for (int i = 0; i < 7; i++) begin
      if (vpat[i]) begin
        send(words[w], w == 3);
        w++;
      end else begin
        tick();
      end
    end
    wait_run();
    chk("thr_nwrites", 32'(wa_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      chk("thr_waddr", 32'(wa_q[i]), 32'(i));
      chk("thr_wdata", wd_q[i], words[i]);
    end

    // full image without host_last
    do_start();
    for (int i = 0; i < NMEM; i++) send(32'(i), 1'b0);
    chk("full_state", 32'(state), 32'd2);
    chk("full_count", 32'(load_count), 32'd128);
    chk("full_err", 32'(load_err), 32'd1);
    chk("full_sum", load_sum, 32'h0);
    tick();
    chk("full_run", 32'(state), 32'd3);
    clear_log();
    host_valid = 1'b1; host_data = $urandom;
    #1;
    chk("run_ready", 32'(host_ready), 32'd0);
    repeat (3) tick();
    host_valid = 1'b0;
    chk("run_nwrites", 32'(wa_q.size()), 32'd0);

    // restart mid-load
    do_start();
    for (int i = 0; i < 3; i++) send(words[i], 1'b0);
    host_start = 1'b1; host_valid = 1'b1; host_data = 32'hDEADBEEF;
    #1;
    chk("rst_ready", 32'(host_ready), 32'd0);
    tick();
    host_start = 1'b0; host_valid = 1'b0;
    chk("rst_count", 32'(load_count), 32'd0);
    chk("rst_sum", load_sum, 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    send(32'hCAFE0001, 1'b1);
    chk("rst_we", 32'(im_we), 32'd1);
    chk("rst_waddr", 32'(im_waddr), 32'd0);
    chk("rst_wdata", im_wdata, 32'hCAFE0001);
    wait_run();

    // reload from RUN
    do_start();
    chk("rel_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rel_state", 32'(state), 32'd1);
    send(32'h12345678, 1'b1);
    wait_run();
    chk("rel_count", 32'(load_count), 32'd1);
    chk("rel_sum", load_sum, 32'h12345678);

    // asynchronous reset mid-load
    do_start();
    send(32'hA5A5A5A5, 1'b0);
    send(32'h5A5A5A5A, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("areset");
    tick();
    reset = 1'b0;
    tick();
    chk("areset_idle", 32'(state), 32'd0);

    // randomized loads against the model
    for (int it = 0; it < 40; it++) begin
      int  len;
      bit  abort;
      bit  aborted;
      len = $urandom_range(1, 12);
      abort = ($urandom_range(0, 7) == 0);
      aborted = 1'b0;
      do_start();
      for (int j = 0; j < len && !aborted; j++) begin
        repeat ($urandom_range(0, 2)) begin
          host_data = $urandom;
          tick();
        end
        if (abort && j == len / 2) aborted = 1'b1;
        else send($urandom, j == len - 1);
      end
      if (!aborted) begin
        if ($urandom_range(0, 5) == 0) begin
          do_start();
        end else begin
          wait_run();
          repeat ($urandom_range(0, 3)) begin
            host_valid = 1'($urandom);
            host_data = $urandom;
            tick();
          end
          host_valid = 1'b0;
        end
      end
    end
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/im_boot_ctrl.md
# im_boot_ctrl

Boot-time controller for the instruction memory. It holds the core in reset while a host streams a program image word by word over a valid/ready channel. It drives the instruction memory's write port with sequential word addresses, then releases the core. It also keeps a word count, an XOR checksum and a truncation flag so the emulation host can confirm the image was loaded.

## Interface
- NMEM, 128: instruction memory depth in 32-bit words; maximum image length.
- AW, 7: word-address width; must satisfy 2**AW == NMEM.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- host_start  input  1  one-cycle pulse; begins a load, or restarts/reloads from any state.
- host_valid  input  1  host_data is valid.
- host_data  input  32  program word.
- host_last  input  1  qualifies host_data as the final image word.
- host_ready  output  1  controller accepts a word this cycle.
- im_we  output  1  instruction memory write enable (registered).
- im_waddr  output  AW  instruction memory word address (registered).
- im_wdata  output  32  instruction memory write data (registered).
- cpu_rst  output  1  holds the core (PC/fetch) in reset while high.
- load_count  output  AW+1  number of words accepted since the last host_start.
- load_sum  output  32  XOR of all words accepted since the last host_start.
- load_err  output  1  sticky flag: the image filled memory without host_last.
- state  output  2  IDLE=0, LOAD=1, FLUSH=2, RUN=3 (debug).

## Operation
- Reset values:
  - state = IDLE, host_ready = 0, im_we = 0, im_waddr = 0, im_wdata = 0.
  - cpu_rst = 1, load_count = 0, load_sum = 0, load_err = 0.
- IDLE:
  - host_ready = 0, cpu_rst = 1.
  - host_start moves to LOAD.
- LOAD:
  - host_ready = !host_start (combinational from the state register and host_start).
  - Accept = host_valid && host_ready.
  - On accept:
    - im_we <= 1, im_waddr <= load_count[AW-1:0], im_wdata <= host_data.
    - load_count <= load_count + 1, load_sum <= load_sum ^ host_data.
  - With no accept, im_we <= 0.
  - On an accept with host_last = 1, or on an accept with load_count == NMEM-1, move to FLUSH.
  - If that final accept has host_last = 0 and load_count == NMEM-1, set load_err <= 1.
- FLUSH:
  - host_ready = 0; the registered write of the final word is on the im_* outputs this cycle.
  - Move to RUN next cycle.
- RUN:
  - cpu_rst = 0, host_ready = 0, im_we = 0.
  - host_valid is ignored.
  - host_start moves to LOAD.
- host_start in any state:
  - next state = LOAD; load_count <= 0, load_sum <= 0, load_err <= 0.
  - No word is accepted in the host_start cycle.
  - An im_we already registered (FLUSH or LOAD) still completes.
- cpu_rst = 1 in IDLE, LOAD and FLUSH; decoded from the state register, no glitches.
- Arithmetic:
  - load_count saturates naturally at NMEM, because LOAD exits on the NMEM-th accept.
  - The address never wraps.

## Timing
- Write latency: a word accepted in cycle N appears as im_we = 1 with its address and data in cycle N+1.
- Final accept in cycle N:
  - FLUSH in N+1 (final write visible).
  - RUN and cpu_rst = 0 in N+2.
- Back-to-back accepts give one write per cycle with no bubbles; host gaps give im_we = 0 cycles.
- host_start in cycle N:
  - state = LOAD, counters cleared in N+1.
  - host_ready first high in N+1.
  - From RUN, cpu_rst returns to 1 in N+1.
- Asynchronous reset mid-operation forces all outputs to their reset values immediately; a partially loaded image is abandoned.

## Test plan
- Reset: assert reset between edges -> all outputs at reset values with no clock edge required; state = 0, cpu_rst = 1.
- 4-word load:
  - Stimulus: host_start, then 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back, host_last on the 4th.
  - Required: im_we pulses at waddr 0..3 with matching data; load_count = 4; load_sum = 0x44444444; load_err = 0; cpu_rst falls 2 cycles after the 4th accept.
- Throttled host: host_valid toggles 1,0,0,1,1,0,1 with 4 words -> exactly 4 writes at waddr 0..3, none duplicated or skipped.
- Full image: 128 words 0x00000000..0x0000007F, no host_last:
  - Required: FLUSH after the 128th accept; load_count = 128; load_err = 1; load_sum = 0x00000000.
  - Required: in RUN, host_valid = 1 gives host_ready = 0 and no writes.
- Restart mid-load: 3 words loaded, then host_start with host_valid = 1 -> that word is not accepted; count = 0, sum = 0; the next accepted word is written at waddr 0; cpu_rst stays 1.
- Reload from RUN: host_start -> cpu_rst = 1 next cycle; a 1-word load with host_last -> back in RUN with load_count = 1.
